// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment encodings and frame-field width helper for the serial display
package display_pkg;

  typedef logic [7:0] segment_t;

  localparam segment_t SEG_0     = 8'h3F;
  localparam segment_t SEG_1     = 8'h06;
  localparam segment_t SEG_2     = 8'h5B;
  localparam segment_t SEG_3     = 8'h4F;
  localparam segment_t SEG_4     = 8'h66;
  localparam segment_t SEG_5     = 8'h6D;
  localparam segment_t SEG_6     = 8'h7D;
  localparam segment_t SEG_7     = 8'h07;
  localparam segment_t SEG_8     = 8'h7F;
  localparam segment_t SEG_9     = 8'h6F;
  localparam segment_t SEG_MINUS = 8'h40;
  localparam segment_t SEG_DP    = 8'h80;
  localparam segment_t SEG_BLANK = 8'h00;

  // Address field must be at least one bit wide even for tiny displays.
  function automatic int addrWidth(input int digits);
    return ($clog2(digits) < 1) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/serial_input_filter.sv
// rtl/serial_input_filter.sv - synchronizer, two-sample agreement filter and rising-edge strobe
module serial_input_filter (
  input  logic clock,
  input  logic reset,
  input  logic sampleTick,
  input  logic rawIn,
  output logic filtered,
  output logic rise
);

  logic [1:0] syncFf;
  logic       prevSample;
  logic       filteredPrev;

  always_ff @(posedge clock) begin
    if (reset) begin
      syncFf       <= 2'b00;
      prevSample   <= 1'b0;
      filtered     <= 1'b0;
      filteredPrev <= 1'b0;
    end else begin
      syncFf       <= {syncFf[0], rawIn};
      filteredPrev <= filtered;
      if (sampleTick) begin
        prevSample <= syncFf[1];
        // Only a level seen on two consecutive ticks is trusted.
        if (syncFf[1] == prevSample)
          filtered <= syncFf[1];
      end
    end
  end

  assign rise = filtered & ~filteredPrev;

endmodule

// File: rtl/multi_digit_serial_display.sv
// rtl/multi_digit_serial_display.sv - serially loaded, multiplexed multi-digit segment display
// Define FRAME_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES idle cycles.
module multi_digit_serial_display
  import display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int FILTER_DIV     = 65536,
  parameter int SCAN_DIV       = 24000,
  parameter int TIMEOUT_CYCLES = 2400000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              serial_clock_in,
  input  logic              serial_data_in,
  output logic [DIGITS-1:0] digit_select_n,
  output logic [7:0]        segment_out,
  output logic              frame_led_n,
  output logic              clock_led_n,
  output logic              data_led_n,
  output logic              frame_valid,
  output logic              frame_error
);

  localparam int ADDR_W     = addrWidth(DIGITS);
  localparam int FRAME_BITS = ADDR_W + 8;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int PRE_W      = (FILTER_DIV > 1) ? $clog2(FILTER_DIV) : 1;
  localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LED_W      = $clog2(FILTER_DIV + 1);

  logic [PRE_W-1:0]      preCount;
  logic                  sampleTick;
  logic                  clockFiltered, dataFiltered, shiftStrobe;
  logic [CNT_W-1:0]      bitCount;
  logic [FRAME_BITS-1:0] shiftReg;
  logic                  frameDone;
  logic [ADDR_W-1:0]     frameAddr;
  logic [7:0]            frameData;
  logic                  addrOk;
  logic                  timeoutHit, timeoutPulse;
  segment_t              digitReg [DIGITS];
  logic [SCAN_W-1:0]     scanCount;
  logic [ADDR_W-1:0]     scanIndex;
  logic [LED_W-1:0]      ledCount;

  always_ff @(posedge clock) begin
    if (reset) begin
      preCount   <= '0;
      sampleTick <= 1'b0;
    end else if (preCount == PRE_W'(FILTER_DIV - 1)) begin
      preCount   <= '0;
      sampleTick <= 1'b1;
    end else begin
      preCount   <= preCount + 1'b1;
      sampleTick <= 1'b0;
    end
  end

  serial_input_filter clockFilter (
    .clock(clock), .reset(reset), .sampleTick(sampleTick),
    .rawIn(serial_clock_in), .filtered(clockFiltered), .rise(shiftStrobe)
  );

  serial_input_filter dataFilter (
    .clock(clock), .reset(reset), .sampleTick(sampleTick),
    .rawIn(serial_data_in), .filtered(dataFiltered), .rise()
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      bitCount  <= '0;
      shiftReg  <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (shiftStrobe) begin
        shiftReg <= {shiftReg[FRAME_BITS-2:0], dataFiltered};
        if (bitCount == CNT_W'(FRAME_BITS - 1)) begin
          bitCount  <= '0;
          frameDone <= 1'b1;
        end else begin
          bitCount <= bitCount + 1'b1;
        end
      end else if (timeoutHit) begin
        bitCount <= '0;
      end
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idleCount;

  assign timeoutHit = (bitCount != '0) && !shiftStrobe &&
                      (idleCount == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      idleCount    <= '0;
      timeoutPulse <= 1'b0;
    end else begin
      timeoutPulse <= timeoutHit;
      if (bitCount == '0 || shiftStrobe || timeoutHit)
        idleCount <= '0;
      else
        idleCount <= idleCount + 1'b1;
    end
  end
`else
  assign timeoutHit   = 1'b0;
  assign timeoutPulse = 1'b0;
`endif

  assign frameAddr = shiftReg[FRAME_BITS-1 -: ADDR_W];
  assign frameData = shiftReg[7:0];
  assign addrOk    = ({1'b0, frameAddr} < (ADDR_W + 1)'(DIGITS));

  assign frame_valid = frameDone & addrOk;
  assign frame_error = (frameDone & ~addrOk) | timeoutPulse;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++)
        digitReg[i] <= SEG_BLANK;
    end else if (frame_valid) begin
      digitReg[frameAddr] <= frameData;
    end
  end

  // Scan outputs read the digit array directly, so a write lands on the display next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      scanCount      <= '0;
      scanIndex      <= '0;
      digit_select_n <= '1;
      segment_out    <= SEG_BLANK;
    end else begin
      digit_select_n <= ~(DIGITS'(1) << scanIndex);
      segment_out    <= digitReg[scanIndex];
      if (scanCount == SCAN_W'(SCAN_DIV - 1)) begin
        scanCount <= '0;
        scanIndex <= (scanIndex == ADDR_W'(DIGITS - 1)) ? '0 : scanIndex + 1'b1;
      end else begin
        scanCount <= scanCount + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      ledCount <= '0;
    else if (frame_valid)
      ledCount <= LED_W'(FILTER_DIV);
    else if (ledCount != '0)
      ledCount <= ledCount - 1'b1;
  end

  assign frame_led_n = (ledCount == '0);
  assign clock_led_n = ~clockFiltered;
  assign data_led_n  = ~dataFiltered;

endmodule

// File: doc/multi_digit_serial_display.md
MULTI_DIGIT_SERIAL_DISPLAY -- requirements
Module: multi_digit_serial_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of multiplexed digits (legal 2..16).
REQ-002 SHALL have parameter FILTER_DIV, default 65536, meaning clock cycles between input filter samples.
REQ-003 SHALL have parameter SCAN_DIV, default 24000, meaning clock cycles each digit stays selected.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2400000, meaning the idle limit for a partial frame.
REQ-005 SHALL derive localparams ADDR_W = max(1, clog2(DIGITS)) and FRAME_BITS = ADDR_W + 8.
REQ-006 SHALL have port clock, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port serial_clock_in, input, 1 bit: async serial clock.
REQ-009 SHALL have port serial_data_in, input, 1 bit: async serial data.
REQ-010 SHALL have port digit_select_n, output, DIGITS bits: one-cold digit enable.
REQ-011 SHALL have port segment_out, output, 8 bits: segments for the selected digit (bit7 = DP).
REQ-012 SHALL have port frame_led_n, output, 1 bit: low for one filter period after a valid frame.
REQ-013 SHALL have port clock_led_n, output, 1 bit: inverse of the filtered serial clock.
REQ-014 SHALL have port data_led_n, output, 1 bit: inverse of the filtered serial data.
REQ-015 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a digit is written.
REQ-016 SHALL have port frame_error, output, 1 bit: one-cycle pulse on a bad address or a timeout.

Function
REQ-017 SHALL pass both serial inputs through a 2-flop synchronizer.
REQ-018 SHALL assert a sample tick once every FILTER_DIV cycles from a prescaler.
REQ-019 SHALL update each filtered signal on a tick only when the current and previous samples agree.
REQ-020 SHALL produce a one-cycle shift strobe on each 0->1 transition of the filtered clock; the bit taken is the filtered data in that cycle.
REQ-021 SHALL shift frames MSB-first: ADDR_W address bits, then 8 segment bits; the bit counter runs 0..FRAME_BITS-1.
REQ-022 SHALL complete a frame on the FRAME_BITS-th strobe: the cycle after, digit[addr] is written and frame_valid pulses, and the bit counter returns to 0.
REQ-023 SHALL, when addr >= DIGITS, not write any digit and pulse frame_error instead of frame_valid.
REQ-024 SHALL run the scan counter 0..SCAN_DIV-1; on wrap, scan index advances, with DIGITS-1 wrapping to 0.
REQ-025 SHALL drive digit_select_n low only at bit scan_index, and segment_out = digit[scan_index], both registered (1-cycle latency).
REQ-026 SHALL give the write when a frame write and a scan advance fall in the same cycle; the new value appears on segment_out no later than 2 cycles after the write.

Reset
REQ-027 SHALL clear on reset: all digit registers 8'h00, digit_select_n all ones, segment_out 0, scan index 0, all counters 0.
REQ-028 SHALL set on reset: filtered signals 0, frame_valid/frame_error 0, all LED outputs 1.
REQ-029 SHALL, on reset mid-frame, discard the partial frame and leave no digit written.

Configuration
REQ-030 SHALL, with FRAME_TIMEOUT_EN defined, count idle cycles while the bit counter is nonzero; at TIMEOUT_CYCLES it clears the bit counter and pulses frame_error.
REQ-031 SHALL, without FRAME_TIMEOUT_EN, omit the idle counter and hold partial frames indefinitely.

Structure
REQ-032 SHALL place the segment encoding constants (0-9, minus, DP, blank) and the frame-field width helper function in package display_pkg.
REQ-033 SHALL implement the synchronizer, filter and edge-detect as one sub-module, serial_input_filter, instantiated once per serial input.

Verification (DIGITS=4, FILTER_DIV=4, SCAN_DIV=8, TIMEOUT_CYCLES=200)
REQ-034 SHALL check: reset released -> digit_select_n=4'b1110, segment_out=8'h00, all LEDs 1.
REQ-035 SHALL check: frame 10'b10_0101_1011 -> one frame_valid pulse; segment_out=8'h5B while digit_select_n=4'b1011.
REQ-036 SHALL check: 1-tick glitch on serial_clock_in -> no shift strobe, bit counter unchanged.
REQ-037 SHALL check: 5 bits then 300 idle cycles, with FRAME_TIMEOUT_EN -> frame_error pulse, next full frame accepted.
REQ-038 SHALL check: DIGITS=3 with address 2'b11 frame -> frame_error pulse, all digits unchanged.
REQ-039 SHALL check: reset asserted after 6 bits -> all digits remain 8'h00, and a following frame decodes correctly.
